// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//   Two-requester round-robin arbiter feeding a single registered output word.
//   A requester's word is accepted whenever it holds the grant and the output
//   register has room: either empty, or being drained by the consumer in the
//   same cycle. Back-to-back transfers therefore run at one word per cycle.
//   When both requesters are valid, the grant goes to the one that did not win
//   last time. The last-grant pointer resets to 1, so requester 0 wins first.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : synchronous active-high reset
//   i0_valid   : requester 0 offers i0_data
//   i0_data    : requester 0 payload [WIDTH-1:0]
//   i0_ready   : requester 0 word accepted this cycle
//   i1_valid   : requester 1 offers i1_data
//   i1_data    : requester 1 payload [WIDTH-1:0]
//   i1_ready   : requester 1 word accepted this cycle
//   out_valid  : output register holds an unconsumed word
//   out_data   : registered selected word [WIDTH-1:0]
//   out_ready  : consumer takes out_data this cycle
//   sel        : index of the requester whose word sits in out_data
//   cnt0/cnt1  : modulo-256 grant counters for requester 0 / 1
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             sel_q;
  logic             last_q;
  logic [7:0]       cnt0_q;
  logic [7:0]       cnt1_q;

  logic             gnt_vld;
  logic             gnt_idx;
  logic             space;
  logic             xfer;
  logic [WIDTH-1:0] data_d;

  // Grant counters wrap silently; no saturation.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  // Grant selection and handshake
  always_comb begin
    gnt_vld = i0_valid | i1_valid;
    gnt_idx = 1'b0;
    if (i0_valid && i1_valid) begin
      gnt_idx = ~last_q;
    end else if (i1_valid) begin
      gnt_idx = 1'b1;
    end
    space    = !out_valid_q || out_ready;
    // Reset gates the handshake so nothing is accepted during the reset cycle.
    xfer     = gnt_vld && space && !rst;
    i0_ready = xfer && !gnt_idx;
    i1_ready = xfer &&  gnt_idx;
    data_d   = gnt_idx ? i1_data : i0_data;
  end

  // Output register stage and control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt0_q      <= 8'd0;
      cnt1_q      <= 8'd0;
    end else begin
      if (xfer) begin
        out_data_q <= data_d;
        sel_q      <= gnt_idx;
        last_q     <= gnt_idx;
        if (gnt_idx) cnt1_q <= wrap_inc(cnt1_q);
        else         cnt0_q <= wrap_inc(cnt0_q);
      end
      case (state_q)
        EMPTY: begin
          if (xfer) begin
            state_q     <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          // Draining with a new grant reloads in place; draining without one empties.
          if (out_ready && !xfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i0_valid, i1_valid, out_ready;
  logic [7:0] i0_data, i1_data;
  logic       i0_ready, i1_ready, out_valid, sel;
  logic [7:0] out_data, cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a one-word buffer plus round-robin pointer and counters.
  bit       m_vld;
  bit [7:0] m_data;
  bit       m_sel;
  bit       m_last;
  bit [7:0] m_cnt0, m_cnt1;

  mux_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // -1 = no grant, otherwise the granted requester index.
  function automatic int exp_grant();
    if (i0_valid && i1_valid) return m_last ? 0 : 1;
    if (i0_valid) return 0;
    if (i1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready(input int n);
    bit room;
    room = !m_vld || out_ready;
    return !rst && room && (exp_grant() == n);
  endfunction

  task automatic model_edge();
    int g;
    g = exp_grant();
    if (rst) begin
      m_vld = 0; m_data = 0; m_sel = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (g >= 0 && (!m_vld || out_ready)) begin
      m_data = (g == 1) ? i1_data : i0_data;
      m_sel  = (g == 1);
      m_last = (g == 1);
      if (g == 1) m_cnt1 = m_cnt1 + 8'd1;
      else        m_cnt0 = m_cnt0 + 8'd1;
      m_vld  = 1;
    end else if (out_ready) begin
      m_vld = 0;
    end
  endtask

  // Advance one clock; the model updates on the same edge as the DUT.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i0_valid = 0; i1_valid = 0; i0_data = 8'h00; i1_data = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; i0_valid = 1; i1_valid = 1; i0_data = 8'h11; i1_data = 8'h22; out_ready = 1;
    tick();
    #1;
    vectors++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b%b expected 00", i0_ready, i1_ready);
    end
    tick();
    rst = 0; idle_inputs();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b d=%h s=%b c0=%0d c1=%0d expected all zero",
               out_valid, out_data, sel, cnt0, cnt1);
    end
  endtask

  task automatic test_single();
    i0_valid = 1; i0_data = 8'h0F; i1_valid = 0; out_ready = 1;
    #1;
    vectors++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      miscompares++; $display("FAIL single_ready: got %b%b expected 10", i0_ready, i1_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F || sel !== 1'b0 || cnt0 !== 8'd1) begin
      miscompares++;
      $display("FAIL single_out: got v=%b d=%h s=%b c0=%0d expected v=1 d=0f s=0 c0=1",
               out_valid, out_data, sel, cnt0);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [4] = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};
    logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    i0_valid = 1; i0_data = 8'h0F; i1_valid = 1; i1_data = 8'hF0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || sel !== exp_s[k]) begin
        miscompares++;
        $display("FAIL contention_%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b",
                 k, out_valid, out_data, sel, exp_d[k], exp_s[k]);
      end
    end
    vectors++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
      miscompares++; $display("FAIL contention_cnt: got %0d/%0d expected 2/2", cnt0, cnt1);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    i0_valid = 1; i0_data = 8'hFA; out_ready = 1;
    tick();
    i0_valid = 0; out_ready = 0; i1_valid = 1; i1_data = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (i1_ready !== 1'b0 || i0_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_ready_%0d: got %b%b expected 00", k, i0_ready, i1_ready);
      end
      tick();
      i1_data = 8'h33 + 8'(k + 1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hFA || sel !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h s=%b expected v=1 d=fa s=0", k, out_valid, out_data, sel);
      end
    end
    out_ready = 1;
    #1;
    vectors++;
    if (i1_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got i1_ready=%b expected 1", i1_ready);
    end
    tick();
    vectors++;
    if (out_data !== 8'h36 || sel !== 1'b1 || cnt1 !== 8'd1) begin
      miscompares++;
      $display("FAIL bp_load: got d=%h s=%b c1=%0d expected d=36 s=1 c1=1", out_data, sel, cnt1);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i1_valid = 1; i1_data = 8'h44; out_ready = 1; tick();
    i1_valid = 0; i0_valid = 1; i0_data = 8'hBF; tick();
    i0_valid = 1; i1_valid = 1; out_ready = 0; rst = 1;
    #1;
    vectors++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_ready: got %b%b expected 00", i0_ready, i1_ready);
    end
    tick();
    rst = 0;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL midrst_state: got v=%b d=%h c0=%0d c1=%0d expected zeros", out_valid, out_data, cnt0, cnt1);
    end
    out_ready = 1; i0_data = 8'h01; i1_data = 8'h02;
    #1;
    vectors++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_first: got %b%b expected 10", i0_ready, i1_ready);
    end
    tick();
    vectors++;
    if (sel !== 1'b0 || out_data !== 8'h01) begin
      miscompares++; $display("FAIL midrst_sel: got s=%b d=%h expected s=0 d=01", sel, out_data);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_wrap();
    do_reset();
    i0_valid = 1; out_ready = 1;
    for (int k = 0; k < 256; k++) begin
      i0_data = 8'($urandom);
      tick();
      if (k == 254) begin
        vectors++;
        if (cnt0 !== 8'd255) begin
          miscompares++; $display("FAIL wrap_255: got %0d expected 255", cnt0);
        end
      end
    end
    vectors++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++; $display("FAIL wrap_zero: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_idle();
    i1_valid = 1; i1_data = 8'h5A; out_ready = 1; tick();
    idle_inputs(); tick();
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'($urandom);
      i0_data = 8'($urandom); i1_data = 8'($urandom);
      tick();
      vectors++;
      if (out_valid !== 1'b0 || cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
        miscompares++;
        $display("FAIL idle_%0d: got v=%b c0=%0d c1=%0d expected v=0 c0=%0d c1=%0d",
                 k, out_valid, cnt0, cnt1, m_cnt0, m_cnt1);
      end
    end
  endtask

  task automatic test_random();
    bit e0, e1;
    for (int k = 0; k < 2000; k++) begin
      rst       = ($urandom_range(63) == 0);
      i0_valid  = 1'($urandom);
      i1_valid  = 1'($urandom);
      i0_data   = 8'($urandom);
      i1_data   = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      e0 = exp_ready(0); e1 = exp_ready(1);
      vectors++;
      if (i0_ready !== e0 || i1_ready !== e1) begin
        miscompares++;
        $display("FAIL rand_ready_%0d: got %b%b expected %b%b", k, i0_ready, i1_ready, e0, e1);
      end
      tick();
      vectors++;
      if (out_valid !== m_vld || (m_vld && (out_data !== m_data || sel !== m_sel)) ||
          cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
        miscompares++;
        $display("FAIL rand_out_%0d: got v=%b d=%h s=%b c=%0d/%0d expected v=%b d=%h s=%b c=%0d/%0d",
                 k, out_valid, out_data, sel, cnt0, cnt1, m_vld, m_data, m_sel, m_cnt0, m_cnt1);
      end
    end
    rst = 0; idle_inputs(); out_ready = 1; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
